// File: rtl/g3f_seq.sv
// Step sequencer for the g3f core: issues shift-enable pulses separated by a
// programmable gap, samples the core after each one and folds it into a signature.
module g3f_seq #(
  parameter int LEN_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] len,
  input  logic [GAP_W-1:0] gap,
  input  logic [2:0]       q_in,
  input  logic [2:0]       p_in,
  output logic             se,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] step_cnt,
  output logic [2:0]       q_cap,
  output logic [2:0]       p_cap,
  output logic [7:0]       sig,
  output logic             lock_err,
  output logic             aborted
);

  typedef enum logic [2:0] {IDLE, PULSE, SAMPLE, GAP, DONE} state_t;

  state_t           state, state_nx;
  logic [LEN_W-1:0] len_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic             zero_run;
  logic [LEN_W-1:0] cnt_inc;
  logic             accept;
  logic             sample_go;
  logic             lock_hit;

  assign cnt_inc   = step_cnt + 1'b1;
  assign accept    = (state == IDLE) && start;
  assign sample_go = (state == SAMPLE) && !abort;
  assign lock_hit  = (q_in == 3'b000);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = (len == '0) ? DONE : PULSE;
      PULSE:  state_nx = abort ? IDLE : SAMPLE;
      SAMPLE: begin
        if (abort)                               state_nx = IDLE;
        else if ((cnt_inc == len_q) || lock_hit) state_nx = DONE;
        else if (gap_q == '0)                    state_nx = PULSE;
        else                                     state_nx = GAP;
      end
      GAP: begin
        if (abort)                state_nx = IDLE;
        else if (gap_cnt == 1'b1) state_nx = PULSE;
      end
      // a zero-length run settles one cycle in DONE before pulsing done
      DONE:   state_nx = (abort || !zero_run) ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      se       <= 1'b0;
      len_q    <= '0;
      gap_q    <= '0;
      gap_cnt  <= '0;
      zero_run <= 1'b0;
      step_cnt <= '0;
      q_cap    <= '0;
      p_cap    <= '0;
      sig      <= '0;
      lock_err <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      state <= state_nx;
      se    <= (state_nx == PULSE);
      if (accept) begin
        len_q    <= len;
        gap_q    <= gap;
        zero_run <= (len == '0);
        step_cnt <= '0;
        sig      <= '0;
        lock_err <= 1'b0;
        aborted  <= 1'b0;
      end
      if ((state != IDLE) && abort) aborted <= 1'b1;
      if (sample_go) begin
        q_cap    <= q_in;
        p_cap    <= p_in;
        step_cnt <= cnt_inc;
        sig      <= {sig[4:0], sig[7:5]} ^ {2'b00, q_in, p_in};
        gap_cnt  <= gap_q;
        if (lock_hit) lock_err <= 1'b1;
      end
      if ((state == GAP) && !abort) gap_cnt <= gap_cnt - 1'b1;
      if (state == DONE) zero_run <= 1'b0;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE) && !zero_run && !abort;

endmodule

// File: tb/tb_g3f_seq.sv
// Scenario bench for g3f_seq: expected se/done cycles are queued at launch and
// matched against the pulses the sequencer produces.
module tb_g3f_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] len = '0;
  logic [3:0] gap = '0;
  logic [2:0] q_in = 3'b101;
  logic [2:0] p_in = 3'b010;
  logic       se, busy, done, lock_err, aborted;
  logic [7:0] step_cnt, sig;
  logic [2:0] q_cap, p_cap;

  int vec = 0;
  int bad = 0;
  int se_q[$];
  int done_q[$];

  g3f_seq #(.LEN_W(8), .GAP_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len), .gap(gap),
    .q_in(q_in), .p_in(p_in), .se(se), .busy(busy), .done(done),
    .step_cnt(step_cnt), .q_cap(q_cap), .p_cap(p_cap), .sig(sig),
    .lock_err(lock_err), .aborted(aborted)
  );

  always #5 clk = ~clk;

  function automatic int pop_se();
    if (se_q.size() == 0) return -1;
    return se_q.pop_front();
  endfunction

  function automatic int pop_done();
    if (done_q.size() == 0) return -1;
    return done_q.pop_front();
  endfunction

  // start is presented during cycle 0; the following negedge belongs to cycle 1
  task automatic launch(input int l, input int g);
    @(negedge clk);
    len = l[7:0]; gap = g[3:0]; start = 1'b1; abort = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    vec++;
    if ({se, busy, done, step_cnt, q_cap, p_cap, sig, lock_err, aborted} !== 31'd0) begin
      bad++; $display("FAIL reset_outputs: got se=%b busy=%b done=%b cnt=%0d q=%b p=%b sig=%h le=%b ab=%b, need all 0",
                      se, busy, done, step_cnt, q_cap, p_cap, sig, lock_err, aborted);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int e;
    q_in = 3'b101; p_in = 3'b010;
    for (int k = 0; k < 3; k++) se_q.push_back(1 + 2*k);
    done_q.push_back(7);
    launch(3, 0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk); start = 1'b0;
      if (se)   begin vec++; e = pop_se();   if (e !== c) begin bad++; $display("FAIL basic_se: se at cycle %0d, expected %0d", c, e); end end
      if (done) begin vec++; e = pop_done(); if (e !== c) begin bad++; $display("FAIL basic_done: done at cycle %0d, expected %0d", c, e); end end
    end
    vec++;
    if (se_q.size() + done_q.size() != 0) begin bad++; $display("FAIL basic_missing: %0d se and %0d done pulses not seen, need 0", se_q.size(), done_q.size()); end
    se_q.delete(); done_q.delete();
    vec++;
    if ({step_cnt, q_cap, p_cap, sig, lock_err, aborted} !== {8'd3, 3'b101, 3'b010, 8'hF1, 2'b00}) begin
      bad++; $display("FAIL basic_result: cnt=%0d q=%b p=%b sig=%h le=%b ab=%b, need 3 101 010 f1 0 0",
                      step_cnt, q_cap, p_cap, sig, lock_err, aborted);
    end
  endtask

  task automatic test_gap;
    int e;
    se_q.push_back(1); se_q.push_back(5);
    done_q.push_back(7);
    launch(2, 2);
    vec++;
    if (busy !== 1'b0) begin bad++; $display("FAIL gap_busy0: busy=%b at cycle 0, need 0", busy); end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk); start = 1'b0;
      vec++;
      if (busy !== (c <= 7)) begin bad++; $display("FAIL gap_busy: busy=%b at cycle %0d, need %b", busy, c, (c <= 7)); end
      if (se)   begin vec++; e = pop_se();   if (e !== c) begin bad++; $display("FAIL gap_se: se at cycle %0d, expected %0d", c, e); end end
      if (done) begin vec++; e = pop_done(); if (e !== c) begin bad++; $display("FAIL gap_done: done at cycle %0d, expected %0d", c, e); end end
    end
    vec++;
    if (se_q.size() + done_q.size() != 0) begin bad++; $display("FAIL gap_missing: %0d se and %0d done pulses not seen, need 0", se_q.size(), done_q.size()); end
    se_q.delete(); done_q.delete();
    vec++;
    if (step_cnt !== 8'd2) begin bad++; $display("FAIL gap_cnt: step_cnt=%0d, need 2", step_cnt); end
  endtask

  task automatic test_zero_len;
    int e;
    done_q.push_back(2);
    launch(0, 3);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); start = 1'b0;
      if (se)   begin vec++; e = pop_se();   if (e !== c) begin bad++; $display("FAIL zero_se: se at cycle %0d, expected %0d", c, e); end end
      if (done) begin vec++; e = pop_done(); if (e !== c) begin bad++; $display("FAIL zero_done: done at cycle %0d, expected %0d", c, e); end end
    end
    vec++;
    if (se_q.size() + done_q.size() != 0) begin bad++; $display("FAIL zero_missing: %0d se and %0d done pulses not seen, need 0", se_q.size(), done_q.size()); end
    se_q.delete(); done_q.delete();
    vec++;
    if ({step_cnt, busy} !== 9'd0) begin bad++; $display("FAIL zero_result: step_cnt=%0d busy=%b, need 0 0", step_cnt, busy); end
  endtask

  task automatic test_lock;
    int e;
    se_q.push_back(1); se_q.push_back(3);
    done_q.push_back(5);
    launch(5, 0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk); start = 1'b0;
      if (se)   begin vec++; e = pop_se();   if (e !== c) begin bad++; $display("FAIL lock_se: se at cycle %0d, expected %0d", c, e); end end
      if (done) begin vec++; e = pop_done(); if (e !== c) begin bad++; $display("FAIL lock_done: done at cycle %0d, expected %0d", c, e); end end
      q_in = (c == 4) ? 3'b000 : 3'b101;
    end
    vec++;
    if (se_q.size() + done_q.size() != 0) begin bad++; $display("FAIL lock_missing: %0d se and %0d done pulses not seen, need 0", se_q.size(), done_q.size()); end
    se_q.delete(); done_q.delete();
    vec++;
    if ({lock_err, step_cnt, q_cap} !== {1'b1, 8'd2, 3'b000}) begin
      bad++; $display("FAIL lock_result: lock_err=%b step_cnt=%0d q_cap=%b, need 1 2 000", lock_err, step_cnt, q_cap);
    end
  endtask

  task automatic test_abort;
    int e;
    se_q.push_back(1);
    launch(3, 2);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = (c == 2);
      if (se)   begin vec++; e = pop_se();   if (e !== c) begin bad++; $display("FAIL abort_se: se at cycle %0d, expected %0d", c, e); end end
      if (done) begin vec++; e = pop_done(); if (e !== c) begin bad++; $display("FAIL abort_done: done at cycle %0d, expected %0d", c, e); end end
      if (c == 4) begin
        vec++;
        if ({busy, aborted, lock_err} !== 3'b010) begin bad++; $display("FAIL abort_idle: busy=%b aborted=%b lock_err=%b, need 0 1 0", busy, aborted, lock_err); end
      end
      if (c > 4) begin
        vec++;
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_noqueue: busy=%b at cycle %0d, need 0", busy, c); end
      end
      abort = (c == 3);
    end
    start = 1'b0;
    vec++;
    if (se_q.size() + done_q.size() != 0) begin bad++; $display("FAIL abort_missing: %0d se and %0d done pulses not seen, need 0", se_q.size(), done_q.size()); end
    se_q.delete(); done_q.delete();
    vec++;
    if (step_cnt !== 8'd1) begin bad++; $display("FAIL abort_hold: step_cnt=%0d, need 1", step_cnt); end
    se_q.push_back(1);
    done_q.push_back(3);
    launch(1, 0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); start = 1'b0;
      if (se)   begin vec++; e = pop_se();   if (e !== c) begin bad++; $display("FAIL rerun_se: se at cycle %0d, expected %0d", c, e); end end
      if (done) begin vec++; e = pop_done(); if (e !== c) begin bad++; $display("FAIL rerun_done: done at cycle %0d, expected %0d", c, e); end end
    end
    vec++;
    if (se_q.size() + done_q.size() != 0) begin bad++; $display("FAIL rerun_missing: %0d se and %0d done pulses not seen, need 0", se_q.size(), done_q.size()); end
    se_q.delete(); done_q.delete();
    vec++;
    if ({aborted, step_cnt} !== {1'b0, 8'd1}) begin bad++; $display("FAIL rerun_result: aborted=%b step_cnt=%0d, need 0 1", aborted, step_cnt); end
  endtask

  task automatic test_reset_mid_run;
    int e;
    launch(3, 0);
    @(negedge clk); start = 1'b0;
    vec++;
    if (se !== 1'b1) begin bad++; $display("FAIL rst_pre: se=%b in PULSE, need 1", se); end
    #2 rst = 1'b1;
    #1;
    vec++;
    if ({se, busy, done, step_cnt, q_cap, p_cap, sig, lock_err, aborted} !== 31'd0) begin
      bad++; $display("FAIL rst_async: got se=%b busy=%b done=%b cnt=%0d q=%b p=%b sig=%h le=%b ab=%b, need all 0",
                      se, busy, done, step_cnt, q_cap, p_cap, sig, lock_err, aborted);
    end
    @(negedge clk); rst = 1'b0;
    se_q.push_back(1);
    done_q.push_back(3);
    launch(1, 0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); start = 1'b0;
      if (se)   begin vec++; e = pop_se();   if (e !== c) begin bad++; $display("FAIL rst_run_se: se at cycle %0d, expected %0d", c, e); end end
      if (done) begin vec++; e = pop_done(); if (e !== c) begin bad++; $display("FAIL rst_run_done: done at cycle %0d, expected %0d", c, e); end end
    end
    vec++;
    if (se_q.size() + done_q.size() != 0) begin bad++; $display("FAIL rst_run_missing: %0d se and %0d done pulses not seen, need 0", se_q.size(), done_q.size()); end
    se_q.delete(); done_q.delete();
    vec++;
    if ({step_cnt, q_cap} !== {8'd1, 3'b101}) begin bad++; $display("FAIL rst_run_result: step_cnt=%0d q_cap=%b, need 1 101", step_cnt, q_cap); end
  endtask

  task automatic test_max_len;
    int e;
    for (int k = 0; k < 255; k++) se_q.push_back(1 + 3*k);
    done_q.push_back(3 + 254*3);
    launch(255, 1);
    for (int c = 1; c <= 770; c++) begin
      @(negedge clk); start = (c == 100);
      if (se)   begin vec++; e = pop_se();   if (e !== c) begin bad++; $display("FAIL max_se: se at cycle %0d, expected %0d", c, e); end end
      if (done) begin vec++; e = pop_done(); if (e !== c) begin bad++; $display("FAIL max_done: done at cycle %0d, expected %0d", c, e); end end
    end
    start = 1'b0;
    vec++;
    if (se_q.size() + done_q.size() != 0) begin bad++; $display("FAIL max_missing: %0d se and %0d done pulses not seen, need 0", se_q.size(), done_q.size()); end
    se_q.delete(); done_q.delete();
    vec++;
    if ({step_cnt, busy} !== {8'd255, 1'b0}) begin bad++; $display("FAIL max_result: step_cnt=%0d busy=%b, need 255 0", step_cnt, busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_zero_len();
    test_lock();
    test_abort();
    test_reset_mid_run();
    test_max_len();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/g3f_seq.md
G3F_SEQ -- requirements
Module: g3f_seq

Interface
REQ-001 Parameter: LEN_W, 8, width of the step-count and length fields.
REQ-002 Parameter: GAP_W, 4, width of the inter-pulse gap field.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  request a run; sampled only in IDLE.
REQ-006 Port: abort  input  1  terminate the current run.
REQ-007 Port: len  input  LEN_W  number of shift-enable steps in the run; latched on an accepted start.
REQ-008 Port: gap  input  GAP_W  idle cycles between steps; latched on an accepted start.
REQ-009 Port: q_in  input  3  core state {Qa,Qb,Qc}.
REQ-010 Port: p_in  input  3  core outputs {P0,P1,P2}.
REQ-011 Port: se  output  1  shift-enable to the g3f core (its SE input).
REQ-012 Port: busy  output  1  high in every state except IDLE.
REQ-013 Port: done  output  1  one-cycle pulse at run completion.
REQ-014 Port: step_cnt  output  LEN_W  number of steps completed in the current or last run.
REQ-015 Port: q_cap, p_cap  output  3 each  last sampled q_in and p_in.
REQ-016 Port: sig  output  8  run signature.
REQ-017 Port: lock_err  output  1  sticky all-zero-state flag.
REQ-018 Port: aborted  output  1  sticky flag set when the last run was aborted.

Function
REQ-019 FSM states SHALL be IDLE, PULSE, SAMPLE, GAP and DONE, and the FSM SHALL leave IDLE only on start=1.
REQ-020 An accepted start SHALL latch len and gap and clear step_cnt, sig, lock_err and aborted.
REQ-021 After an accepted start, the next state SHALL be PULSE, or DONE if len=0, in which case se never asserts.
REQ-022 se SHALL be 1 only in PULSE, for exactly one cycle per step, and SHALL be registered (glitch-free).
REQ-023 PULSE SHALL always go to SAMPLE.
REQ-024 In SAMPLE the block SHALL capture q_cap<=q_in and p_cap<=p_in, increment step_cnt, and update sig<={sig[4:0],sig[7:5]} ^ {2'b00,q_in,p_in}.
REQ-025 From SAMPLE, the FSM SHALL go to DONE if the new step_cnt equals len or if q_in=000.
REQ-026 From SAMPLE, if neither DONE condition holds, the FSM SHALL go to PULSE when gap=0 and otherwise to GAP.
REQ-027 GAP SHALL last exactly gap cycles and then go to PULSE.
REQ-028 When q_in=000 is sampled in SAMPLE, lock_err SHALL set and the run SHALL end early with done asserted.
REQ-029 DONE SHALL assert done for one cycle and then return to IDLE.
REQ-030 Timing: if start is sampled at cycle 0, step k SHALL PULSE at cycle 1+k(2+gap) and SAMPLE at cycle 2+k(2+gap), and done SHALL assert at cycle 3+(len-1)(2+gap).
REQ-031 An abort in any busy state SHALL force IDLE on the next edge, with se=0, done not pulsed and aborted=1; step_cnt, captures and sig SHALL hold.
REQ-032 If abort and a completion condition occur in the same cycle, abort SHALL win.
REQ-033 A start asserted while busy SHALL be ignored and SHALL NOT be queued.
REQ-034 step_cnt SHALL NOT wrap, because len bounds it; len=2^LEN_W-1 SHALL be legal.

Reset
REQ-035 rst=1 SHALL immediately force IDLE and set se, busy, done, step_cnt, q_cap, p_cap, sig, lock_err and aborted to 0.
REQ-036 Reset mid-run SHALL drop se within the same cycle (asynchronously) and SHALL NOT produce a done pulse.

Verification
REQ-037 len=3, gap=0, q_in fixed 101, p_in fixed 010 -> se high at cycles 1,3,5; done at cycle 7; step_cnt=3; q_cap=101; p_cap=010.
REQ-038 len=2, gap=2 -> se at cycles 1 and 5; done at cycle 7; busy high for cycles 1-7.
REQ-039 len=0 -> done at cycle 2, se never high, step_cnt=0.
REQ-040 len=5, q_in=000 at the second SAMPLE -> lock_err=1, step_cnt=2, done pulsed, no third se.
REQ-041 abort during GAP of step 1 -> IDLE next cycle, aborted=1, no done, further starts ignored while busy and accepted in IDLE.
REQ-042 Async rst asserted mid-PULSE -> se=0 before the next edge; all outputs 0; start after reset is released runs normally.
